// File: rtl/comp_sel_pkg.sv
// Shared types and defaults for the component select decoder.
// Holds the FSM state type, default widths and a fixed-width one-hot helper.
package comp_sel_pkg;

  localparam int unsigned COMP_SEL_ADDR_W  = 3;
  localparam int unsigned COMP_SEL_DWELL_W = 8;
  localparam int unsigned COMP_SEL_OUT_W   = 1 << COMP_SEL_ADDR_W;

  // Scan states exist in the type either way; they are unreachable when auto-scan is not built.
  typedef enum logic [2:0] {
    StOff,
    StGuard,
    StOn,
    StScanGuard,
    StScanOn
  } comp_sel_state_e;

  // One-hot of an address at the default width.
  function automatic logic [COMP_SEL_OUT_W-1:0] onehot(input logic [COMP_SEL_ADDR_W-1:0] addr);
    logic [COMP_SEL_OUT_W-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational address to one-hot decoder with an enable gate.
// The caller registers the result; nothing here holds state.
module onehot_decode
  import comp_sel_pkg::*;
#(
  parameter int unsigned ADDR_W = COMP_SEL_ADDR_W
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_en,
  output logic [(1<<ADDR_W)-1:0] o_onehot
);

  // Exactly one bit set when enabled, all zero otherwise.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/component_select_decoder.sv
// Registered break-before-make one-hot select decoder for on-chip components.
// Every channel change passes through an all-zero guard cycle, so two selects
// are never high together. Define COMP_SEL_AUTOSCAN_EN to build the auto-scan
// that walks every channel with a programmable dwell; without it scan_start and
// dwell are ignored and scan_busy/scan_done are tied low.
module component_select_decoder
  import comp_sel_pkg::*;
#(
  parameter int unsigned ADDR_W  = COMP_SEL_ADDR_W,
  parameter int unsigned DWELL_W = COMP_SEL_DWELL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   load,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   scan_start,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(1<<ADDR_W)-1:0] out,
  output logic [ADDR_W-1:0]      sel_q,
  output logic                   valid,
  output logic                   scan_busy,
  output logic                   scan_done
);

  localparam int unsigned OUT_W = 1 << ADDR_W;

  comp_sel_state_e    r_state;
  comp_sel_state_e    w_state_d;
  logic [ADDR_W-1:0]  r_sel;
  logic [ADDR_W-1:0]  w_sel_d;
  logic [OUT_W-1:0]   r_out;
  logic [OUT_W-1:0]   w_onehot;
  logic               r_valid;
  logic               w_on_d;
  logic               w_scan_go;

`ifdef COMP_SEL_AUTOSCAN_EN
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_d;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_d;
  logic               r_busy;
  logic               r_done;
  logic               w_done_d;

  assign w_scan_go = enable & scan_start;
`else
  logic w_unused_scan;

  assign w_scan_go     = 1'b0;
  assign w_unused_scan = scan_start ^ (^dwell);
`endif

  // Next state and next channel; enable loss always wins, scan start beats load.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
`ifdef COMP_SEL_AUTOSCAN_EN
    w_dwell_d = r_dwell;
    w_cnt_d   = r_cnt;
    w_done_d  = 1'b0;
`endif
    unique case (r_state)
      StOff: begin
        if (w_scan_go) begin
          w_state_d = StScanGuard;
          w_sel_d   = '0;
`ifdef COMP_SEL_AUTOSCAN_EN
          w_dwell_d = dwell;
`endif
        end else if (enable && load) begin
          w_sel_d   = addr;
          w_state_d = StGuard;
        end
      end
      StGuard: begin
        if (!enable) begin
          w_state_d = StOff;
        end else if (load) begin
          // Re-load restarts the guard: one more zero cycle on the new channel.
          w_sel_d = addr;
        end else begin
          w_state_d = StOn;
        end
      end
      StOn: begin
        if (!enable) begin
          w_state_d = StOff;
        end else if (w_scan_go) begin
          w_state_d = StScanGuard;
          w_sel_d   = '0;
`ifdef COMP_SEL_AUTOSCAN_EN
          w_dwell_d = dwell;
`endif
        end else if (load && (addr != r_sel)) begin
          w_sel_d   = addr;
          w_state_d = StGuard;
        end
      end
`ifdef COMP_SEL_AUTOSCAN_EN
      StScanGuard: begin
        if (!enable) begin
          w_state_d = StOff;
        end else begin
          w_state_d = StScanOn;
          w_cnt_d   = r_dwell;
        end
      end
      StScanOn: begin
        if (!enable) begin
          w_state_d = StOff;
        end else if (r_cnt == '0) begin
          if (r_sel == ADDR_W'(OUT_W - 1)) begin
            w_state_d = StOff;
            w_done_d  = 1'b1;
          end else begin
            w_sel_d   = r_sel + 1'b1;
            w_state_d = StScanGuard;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
`endif
      default: w_state_d = StOff;
    endcase
  end

  assign w_on_d = (w_state_d == StOn) || (w_state_d == StScanOn);

  onehot_decode #(
    .ADDR_W (ADDR_W)
  ) u_onehot_decode (
    .i_addr   (w_sel_d),
    .i_en     (w_on_d),
    .o_onehot (w_onehot)
  );

  // State, channel and decoded select all land in the same flops, so out never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StOff;
      r_sel   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_out   <= w_onehot;
      r_valid <= w_on_d;
    end
  end

`ifdef COMP_SEL_AUTOSCAN_EN
  // Scan bookkeeping: latched dwell, per-channel countdown and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_dwell <= w_dwell_d;
      r_cnt   <= w_cnt_d;
      r_busy  <= (w_state_d == StScanGuard) || (w_state_d == StScanOn);
      r_done  <= w_done_d;
    end
  end

  assign scan_busy = r_busy;
  assign scan_done = r_done;
`else
  assign scan_busy = 1'b0;
  assign scan_done = 1'b0;
`endif

  assign out   = r_out;
  assign sel_q = r_sel;
  assign valid = r_valid;

endmodule

// File: tb/tb_component_select_decoder.sv
// Bench for component_select_decoder: directed literal checks plus randomized
// stimulus compared every cycle against a behavioural model of the select rules.
module tb_component_select_decoder;

`ifdef COMP_SEL_AUTOSCAN_EN
  localparam bit HasScan = 1'b1;
`else
  localparam bit HasScan = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [2:0] addr = '0;
  logic [3:0] addr4 = '0;
  logic       scan_start = 1'b0;
  logic [7:0] dwell = '0;

  logic [7:0]  out;
  logic [2:0]  sel_q;
  logic        valid, scan_busy, scan_done;
  logic [15:0] out4;
  logic [3:0]  sel4;
  logic        valid4, busy4, done4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  component_select_decoder u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .addr(addr),
    .scan_start(scan_start), .dwell(dwell), .out(out), .sel_q(sel_q), .valid(valid),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  component_select_decoder #(.ADDR_W(4), .DWELL_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .addr(addr4),
    .scan_start(scan_start), .dwell(dwell), .out(out4), .sel_q(sel4), .valid(valid4),
    .scan_busy(busy4), .scan_done(done4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = nothing selected, 1 = waiting out the zero gap, 2 = channel live.
  // A scan is a precomputed list of per-cycle (channel, live) entries.
  int  m_mode = 0;
  int  m_sel = 0;
  bit  m_on = 0;
  bit  m_scan = 0;
  bit  m_done = 0;
  int  sq[$];

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_on = 0; m_scan = 0; m_done = 0;
    sq.delete();
  endtask

  task automatic model_step();
    bit en, ld, ss;
    int ad, dw, e;
    en = enable; ld = load; ss = scan_start; ad = int'(addr); dw = int'(dwell);
    m_done = 0;
    if (m_scan) begin
      if (!en) begin
        m_scan = 0; m_mode = 0; m_on = 0; sq.delete();
      end else if (sq.size() == 0) begin
        m_scan = 0; m_mode = 0; m_on = 0; m_done = 1;
      end else begin
        e = sq.pop_front(); m_sel = e / 2; m_on = (e % 2) == 1;
      end
    end else if (HasScan && en && ss && m_mode != 1) begin
      for (int ch = 0; ch < 8; ch++) begin
        sq.push_back(ch * 2);
        for (int k = 0; k <= dw; k++) sq.push_back(ch * 2 + 1);
      end
      m_scan = 1;
      e = sq.pop_front(); m_sel = e / 2; m_on = (e % 2) == 1;
    end else begin
      if (!en) m_mode = 0;
      else if (m_mode == 0) begin
        if (ld) begin m_sel = ad; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (ld) m_sel = ad; else m_mode = 2;
      end else if (ld && ad != m_sel) begin
        m_sel = ad; m_mode = 1;
      end
      m_on = (m_mode == 2);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Single compare process: model vs DUT on every falling edge.
  logic [7:0] e_out;
  always @(negedge clk) begin
    e_out = m_on ? (8'd1 << m_sel) : 8'd0;
    chk("out", 32'(out), 32'(e_out));
    chk("valid", 32'(valid), 32'(m_on));
    chk("sel_q", 32'(sel_q), 32'(m_sel));
    chk("scan_busy", 32'(scan_busy), 32'(m_scan));
    chk("scan_done", 32'(scan_done), 32'(m_done));
    chk("onehot8", 32'($countones(out) <= 1 && (out == 0 || valid)), 32'd1);
    chk("onehot16", 32'($countones(out4) <= 1 && (out4 == 0 || valid4)), 32'd1);
  end

  task automatic drive(input bit en, input bit ld, input int a, input bit ss, input int dw);
    enable = en; load = ld; addr = a[2:0]; addr4 = a[3:0]; scan_start = ss; dwell = dw[7:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(scan_busy), 32'h0);
    #20 rst_n = 1'b1;

    // Load 5: one zero cycle, then 8'h20.
    drive(1, 1, 5, 0, 0);
    chk("ld5_gap", 32'(out), 32'h00);
    drive(1, 0, 0, 0, 0);
    chk("ld5_on", 32'(out), 32'h20);
    chk("ld5_valid", 32'(valid), 32'h1);

    // Switch to 2 with a gap, then reload 2 with no gap.
    drive(1, 1, 2, 0, 0);
    chk("ld2_gap", 32'(out), 32'h00);
    drive(1, 0, 0, 0, 0);
    chk("ld2_on", 32'(out), 32'h04);
    drive(1, 1, 2, 0, 0);
    chk("ld2_same", 32'(out), 32'h04);
    drive(1, 0, 0, 0, 0);
    chk("ld2_hold", 32'(out), 32'h04);

    // Enable low beats load.
    drive(0, 1, 3, 0, 0);
    chk("dis_out", 32'(out), 32'h00);
    chk("dis_sel", 32'(sel_q), 32'h2);
    chk("dis_valid", 32'(valid), 32'h0);
    drive(0, 0, 0, 0, 0);
    chk("dis_stay", 32'(out), 32'h00);

    // Async reset while ON clears immediately.
    drive(1, 1, 6, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("on6", 32'(out), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_valid", 32'(valid), 32'h0);
    chk("arst_sel", 32'(sel_q), 32'h0);
    rst_n = 1'b1;

    // Wide instance sweep.
    drive(1, 1, 15, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("w15", 32'(out4), 32'h8000);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, i, 0, 0);
      chk("w_gap", 32'(out4), 32'h0);
      drive(1, 0, 0, 0, 0);
      chk("w_on", 32'(out4), 32'h1 << i);
    end

`ifdef COMP_SEL_AUTOSCAN_EN
    // Full scan with dwell 2: each channel three cycles, zero between.
    drive(1, 0, 0, 1, 2);
    chk("sc_g0", 32'(out), 32'h0);
    chk("sc_busy", 32'(scan_busy), 32'h1);
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < 3; k++) begin
        drive(1, 1, 4, 0, 2);
        chk("sc_on", 32'(out), 32'h1 << ch);
      end
      drive(1, 0, 0, 0, 2);
      chk("sc_zero", 32'(out), 32'h0);
      chk("sc_done", 32'(scan_done), (ch == 7) ? 32'h1 : 32'h0);
      chk("sc_busy2", 32'(scan_busy), (ch == 7) ? 32'h0 : 32'h1);
    end
    drive(1, 0, 0, 0, 2);
    chk("sc_done_pulse", 32'(scan_done), 32'h0);

    // Drop enable at channel 3.
    begin
      int n;
      n = 0;
      drive(1, 0, 0, 1, 2);
      while (out !== 8'h08 && n < 100) begin
        drive(1, 0, 0, 0, 2);
        n++;
      end
      chk("sc_reach3", 32'(n < 100), 32'h1);
      drive(0, 0, 0, 0, 2);
      chk("ab_out", 32'(out), 32'h0);
      chk("ab_busy", 32'(scan_busy), 32'h0);
      chk("ab_done", 32'(scan_done), 32'h0);
      drive(0, 0, 0, 0, 2);
      chk("ab_done2", 32'(scan_done), 32'h0);
    end
`endif

    // Randomized phase.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 39) == 0, int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
